// File: rtl/spio_pkg.sv
// Shared types and default geometry for the serial LED / GPIO port.
package spio_pkg;

  // Serialiser phases: clear the chain, shift the frame, latch it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } spio_state_e;

  // Default field widths of the CPU write word {gpio, led, cnt}.
  localparam int LED_BITS_DEF  = 16;
  localparam int GPIO_BITS_DEF = 14;
  localparam int CNT_BITS_DEF  = 2;

  // Field offsets within the write word, LSB first.
  localparam int CNT_LSB    = 0;
  localparam int LED_LSB    = CNT_LSB + CNT_BITS_DEF;
  localparam int GPIO_LSB   = LED_LSB + LED_BITS_DEF;
  localparam int DATA_W_DEF = GPIO_LSB + GPIO_BITS_DEF;

  // Power-on LED pattern.
  localparam logic [LED_BITS_DEF-1:0] LED_RST_DEF = 16'h5A5A;

endpackage

// File: rtl/spio_ser_if.sv
// CPU-side bus of the serial LED / GPIO port.
//
// Handshake: EN is a write strobe with no backpressure; every cycle with EN=1
// is one accepted write of P_Data. Start is a refresh request that is never
// refused: while busy=1 it is remembered and served once the current frame
// ends. rd_data is a plain readback of the registers, valid every cycle.
interface spio_ser_if #(
  parameter int DATA_W = 32
);
  logic              EN;
  logic              Start;
  logic [DATA_W-1:0] P_Data;
  logic [DATA_W-1:0] rd_data;
  logic              busy;

  modport master (output EN, output Start, output P_Data, input rd_data, input busy);
  modport slave  (input EN, input Start, input P_Data, output rd_data, output busy);
endinterface

// File: rtl/spio_p2s.sv
// Parallel-to-serial engine driving an LED shift-register chain:
// clear, shift LED_BITS bits MSB first, then latch, all at a divided clock.
module spio_p2s
  import spio_pkg::*;
#(
  parameter int LED_BITS = 16,
  parameter int DIV      = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [LED_BITS-1:0] data_i,
  output logic                busy_o,
  output logic                led_clk_o,
  output logic                led_sout_o,
  output logic                led_clrn_o,
  output logic                led_pen_o,
  output spio_state_e         state_o
);

  // One phase or bit period is 2*DIV system clocks.
  localparam int DW = $clog2(2 * DIV);
  localparam int BW = (LED_BITS > 1) ? $clog2(LED_BITS) : 1;
  localparam logic [DW-1:0] PER_LAST = DW'(2 * DIV - 1);
  localparam logic [DW-1:0] HALF     = DW'(DIV);
  localparam logic [BW-1:0] BIT_LAST = BW'(LED_BITS - 1);

  spio_state_e         state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [LED_BITS-1:0] shift_q, shift_d;

  // State, divider, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic; the shift register advances at the end of each bit
  // period so led_sout is steady for the whole period around the clock edge.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CLR;
          div_d   = '0;
          bit_d   = '0;
          shift_d = data_i;
        end
      end
      CLR: begin
        if (div_q == PER_LAST) begin
          state_d = SHIFT;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT: begin
        if (div_q == PER_LAST) begin
          div_d   = '0;
          shift_d = shift_q << 1;
          if (bit_q == BIT_LAST) state_d = LATCH;
          else                   bit_d   = bit_q + 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      LATCH: begin
        if (div_q == PER_LAST) begin
          state_d = IDLE;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Chain outputs decoded from registered state only.
  always_comb begin
    busy_o     = (state_q != IDLE);
    led_clrn_o = (state_q != CLR);
    led_pen_o  = (state_q == LATCH);
    led_clk_o  = (state_q == SHIFT) && (div_q >= HALF);
    led_sout_o = (state_q == SHIFT) && shift_q[LED_BITS-1];
    state_o    = state_q;
  end

endmodule

// File: rtl/spio_ser.sv
// Parallel I/O port: counter-select, LED and GPIO registers written from the
// CPU bus, with the LED value mirrored onto an external serial chain.
module spio_ser
  import spio_pkg::*;
#(
  parameter int LED_BITS  = LED_BITS_DEF,
  parameter int GPIO_BITS = GPIO_BITS_DEF,
  parameter int CNT_BITS  = CNT_BITS_DEF,
  parameter int DATA_W    = GPIO_BITS + LED_BITS + CNT_BITS,
  parameter int DIV       = 2,
  parameter bit AUTO      = 1'b1,
  parameter logic [LED_BITS-1:0] LED_RST = LED_BITS'(LED_RST_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  spio_ser_if.slave            bus,
  output logic [CNT_BITS-1:0]  counter_set,
  output logic [LED_BITS-1:0]  LED_out,
  output logic [GPIO_BITS-1:0] GPIOf0,
  output logic                 led_clk,
  output logic                 led_sout,
  output logic                 led_clrn,
  output logic                 LED_PEN,
  output spio_state_e          dbg_state
);

  localparam int L_LO = CNT_BITS;
  localparam int G_LO = CNT_BITS + LED_BITS;

  logic [CNT_BITS-1:0]  cnt_q;
  logic [LED_BITS-1:0]  led_q;
  logic [GPIO_BITS-1:0] gpio_q;
  logic                 pending_q, pending_d;

  logic [CNT_BITS-1:0]  wr_cnt;
  logic [LED_BITS-1:0]  wr_led;
  logic [GPIO_BITS-1:0] wr_gpio;
  logic                 req, start, p2s_busy;
  logic [LED_BITS-1:0]  snap;

  // Write-word split, refresh request and snapshot selection. A write in the
  // same cycle as the start is folded in so the frame shows the new value.
  always_comb begin
    wr_cnt    = bus.P_Data[0 +: CNT_BITS];
    wr_led    = bus.P_Data[L_LO +: LED_BITS];
    wr_gpio   = bus.P_Data[G_LO +: GPIO_BITS];
    req       = bus.Start || (AUTO && bus.EN && (wr_led != led_q));
    start     = !p2s_busy && (req || pending_q);
    snap      = ~(bus.EN ? wr_led : led_q);
    pending_d = pending_q;
    if (start)                pending_d = 1'b0;
    else if (p2s_busy && req) pending_d = 1'b1;
  end

  // Bus registers and the pending-refresh flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      led_q     <= LED_RST;
      gpio_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (bus.EN) begin
        cnt_q  <= wr_cnt;
        led_q  <= wr_led;
        gpio_q <= wr_gpio;
      end
    end
  end

  spio_p2s #(
    .LED_BITS (LED_BITS),
    .DIV      (DIV)
  ) u_p2s (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .data_i     (snap),
    .busy_o     (p2s_busy),
    .led_clk_o  (led_clk),
    .led_sout_o (led_sout),
    .led_clrn_o (led_clrn),
    .led_pen_o  (LED_PEN),
    .state_o    (dbg_state)
  );

  assign counter_set = cnt_q;
  assign LED_out     = led_q;
  assign GPIOf0      = gpio_q;
  assign bus.busy    = p2s_busy;
  assign bus.rd_data = {gpio_q, led_q, cnt_q};

endmodule

// File: tb/tb_spio_ser.sv
// Bench for spio_ser with default parameters (16 LEDs, DIV=2, AUTO=1).
module tb_spio_ser;
  import spio_pkg::*;

  localparam int FRAME = 72;   // 2*DIV*(LED_BITS+2)
  localparam int PER   = 4;    // 2*DIV

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spio_ser_if #(.DATA_W(32)) bus ();

  logic [1:0]  counter_set;
  logic [15:0] LED_out;
  logic [13:0] GPIOf0;
  logic        led_clk, led_sout, led_clrn, LED_PEN;
  spio_state_e dbg_state;

  spio_ser dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .counter_set (counter_set),
    .LED_out     (LED_out),
    .GPIOf0      (GPIOf0),
    .led_clk     (led_clk),
    .led_sout    (led_sout),
    .led_clrn    (led_clrn),
    .LED_PEN     (LED_PEN),
    .dbg_state   (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: register contents plus frame position in cycles.
  logic [15:0] m_led;
  logic [1:0]  m_cnt;
  logic [13:0] m_gpio;
  logic [15:0] m_snap;
  int          m_rem;
  bit          m_pend;

  // Scoreboard: frames expected (bits as they appear on the wire) and seen.
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [15:0] cap;
  int          cap_n;
  logic        prev_lclk, prev_pen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model update for one clock edge with the given inputs.
  task automatic model_edge(input logic r, input logic en, input logic st, input logic [31:0] d);
    logic [15:0] nl;
    logic        req;
    nl = d[17:2];
    if (r) begin
      if (m_rem > 0) void'(exp_q.pop_back());
      m_led = 16'h5A5A; m_cnt = '0; m_gpio = '0;
      m_rem = 0; m_pend = 0;
      return;
    end
    req = st || (en && (nl != m_led));
    if (m_rem == 0) begin
      if (req || m_pend) begin
        m_snap = ~(en ? nl : m_led);
        exp_q.push_back(m_snap);
        m_rem  = FRAME;
        m_pend = 0;
      end
    end else begin
      m_rem--;
      if (req) m_pend = 1;
    end
    if (en) begin
      m_led = nl; m_cnt = d[1:0]; m_gpio = d[31:18];
    end
  endtask

  // Compare every output against the model and capture the serial stream.
  task automatic check_all();
    int          p;
    logic        e_clrn, e_pen, e_clk, e_sout;
    spio_state_e e_st;
    e_clrn = 1'b1; e_pen = 1'b0; e_clk = 1'b0; e_sout = 1'b0; e_st = IDLE;
    if (m_rem > 0) begin
      p = FRAME - m_rem;
      if (p < PER) begin
        e_clrn = 1'b0; e_st = CLR;
      end else if (p >= FRAME - PER) begin
        e_pen = 1'b1; e_st = LATCH;
      end else begin
        e_st   = SHIFT;
        e_clk  = ((p - PER) % PER) >= (PER / 2);
        e_sout = m_snap[15 - (p - PER) / PER];
      end
    end
    chk("busy",        32'(bus.busy),    32'(m_rem > 0));
    chk("counter_set", 32'(counter_set), 32'(m_cnt));
    chk("LED_out",     32'(LED_out),     32'(m_led));
    chk("GPIOf0",      32'(GPIOf0),      32'(m_gpio));
    chk("rd_data",     bus.rd_data,      {m_gpio, m_led, m_cnt});
    chk("led_clrn",    32'(led_clrn),    32'(e_clrn));
    chk("LED_PEN",     32'(LED_PEN),     32'(e_pen));
    chk("led_clk",     32'(led_clk),     32'(e_clk));
    chk("led_sout",    32'(led_sout),    32'(e_sout));
    chk("state",       32'(dbg_state),   32'(e_st));
    if (led_clk && !prev_lclk) begin
      cap   = {cap[14:0], led_sout};
      cap_n = cap_n + 1;
    end
    if (LED_PEN && !prev_pen) begin
      chk("bit_count", 32'(cap_n), 32'd16);
      got_q.push_back(cap);
      cap_n = 0;
    end
    if (rst) cap_n = 0;
    prev_lclk = led_clk;
    prev_pen  = LED_PEN;
  endtask

  // Driver: apply inputs for one cycle, advance the model, check outputs.
  task automatic step(input logic r, input logic en, input logic st, input logic [31:0] d);
    rst = r; bus.EN = en; bus.Start = st; bus.P_Data = d;
    @(posedge clk);
    model_edge(r, en, st, d);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Bounded by the model: at most two frames can be outstanding.
  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((m_rem > 0 || m_pend) && guard < 4 * FRAME) begin
      idle(1);
      guard++;
    end
    chk("wait_idle_bound", 32'(guard < 4 * FRAME), 32'd1);
    idle(1);
  endtask

  function automatic logic [15:0] last_got(input int back);
    logic [15:0] v;
    v = 'x;
    if (got_q.size() > back) v = got_q[got_q.size() - 1 - back];
    return v;
  endfunction

  initial begin
    int bsy_n, clr_n, pen_n, nframes;
    logic [31:0] d;
    logic        en, st, r;
    cap = '0; cap_n = 0; prev_lclk = 1'b0; prev_pen = 1'b0;
    m_rem = 0; m_pend = 0; m_snap = '0;

    // Reset for two cycles.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_rd_data", bus.rd_data, 32'h0001_6968);
    chk("rst_led",     32'(LED_out), 32'h5A5A);
    chk("rst_clrn",    32'(led_clrn), 32'd1);
    chk("rst_busy",    32'(bus.busy), 32'd0);
    chk("rst_state",   32'(dbg_state), 32'(IDLE));

    // Explicit Start with the reset pattern.
    step(1'b0, 1'b0, 1'b1, 32'h0);
    chk("start_clrn", 32'(led_clrn), 32'd0);
    bsy_n = 32'(bus.busy); clr_n = 32'(!led_clrn); pen_n = 32'(LED_PEN);
    repeat (99) begin
      idle(1);
      bsy_n += 32'(bus.busy);
      clr_n += 32'(!led_clrn);
      pen_n += 32'(LED_PEN);
    end
    chk("busy_len",   32'(bsy_n), 32'd72);
    chk("clr_len",    32'(clr_n), 32'd4);
    chk("pen_len",    32'(pen_n), 32'd4);
    chk("start_bits", 32'(last_got(0)), 32'hA5A5);

    // Field decode; AUTO starts a frame on the changed LED value.
    step(1'b0, 1'b1, 1'b0, 32'h1234ABCD);
    chk("wr_cnt",  32'(counter_set), 32'h1);
    chk("wr_led",  32'(LED_out),     32'h2AF3);
    chk("wr_gpio", 32'(GPIOf0),      32'h048D);
    chk("wr_busy", 32'(bus.busy),    32'd1);
    wait_idle();
    chk("auto_bits", 32'(last_got(0)), 32'hD50C);

    // Write during a frame: snapshot kept, pending frame follows; extra
    // Start pulses collapse into the same pending refresh.
    nframes = got_q.size();
    step(1'b0, 1'b0, 1'b1, 32'h0);
    idle(19);
    step(1'b0, 1'b1, 1'b0, {14'h0, 16'hFFFF, 2'b00});
    idle(5);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    idle(7);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    wait_idle();
    chk("pend_frames", 32'(got_q.size() - nframes), 32'd2);
    chk("pend_snap",   32'(last_got(1)), 32'hD50C);
    chk("pend_new",    32'(last_got(0)), 32'h0000);

    // Same LED value with a new counter_set: no frame.
    step(1'b0, 1'b1, 1'b0, {14'h3, 16'hFFFF, 2'b10});
    chk("same_cnt", 32'(counter_set), 32'h2);
    repeat (4) begin
      idle(1);
      chk("same_nobusy", 32'(bus.busy), 32'd0);
    end

    // Reset mid-SHIFT with a refresh pending.
    step(1'b0, 1'b0, 1'b1, 32'h0);
    idle(30);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("abort_state", 32'(dbg_state), 32'(IDLE));
    chk("abort_led",   32'(LED_out),   32'h5A5A);
    chk("abort_pen",   32'(LED_PEN),   32'd0);
    repeat (6) begin
      idle(1);
      chk("abort_no_pend", 32'(bus.busy), 32'd0);
    end

    // Randomized traffic against the model.
    repeat (600) begin
      d  = $urandom;
      en = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 31) == 0);
      r  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 1) == 1) d[17:2] = m_led;
      step(r, en, st, d);
    end
    wait_idle();

    // Scoreboard: every expected frame seen, in order.
    chk("frame_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("frame_data", 32'(got_q[i]), 32'(exp_q[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spio_ser.md
# spio_ser

Parametrised successor to the fixed 16-LED parallel I/O port. It decodes a CPU data word into `counter_set`, LED and GPIO registers, and drives an external LED shift-register chain (clear, shift, latch) at a divided serial clock. A busy indication and pending-refresh logic ensure no LED update is lost while a frame is in flight. It sits on the CPU I/O bus next to the counter and seven-segment peripherals.

## Interface
- `LED_BITS`, 16, number of LEDs in the chain; ≥1
- `GPIO_BITS`, 14, width of the general-purpose output field
- `CNT_BITS`, 2, width of `counter_set`
- `DATA_W`, `GPIO_BITS+LED_BITS+CNT_BITS` (32), width of `P_Data`
- `DIV`, 2, system clocks per serial-clock half period; ≥1
- `AUTO`, 1, 1 = a write that changes the LED value requests a refresh automatically
- `LED_RST`, 16'h5A5A, LED register reset value (`LED_BITS` wide)
- `clk` in 1: single clock; all state updates on its rising edge
- `rst` in 1: reset, synchronous, active-high
- `EN` in 1: write strobe for `P_Data`
- `Start` in 1: explicit refresh request, one-cycle pulse or level
- `P_Data` in `DATA_W`: write data, split as {gpio, led, cnt}, MSB to LSB
- `counter_set` out `CNT_BITS`: counter-select register
- `LED_out` out `LED_BITS`: LED register, parallel copy
- `GPIOf0` out `GPIO_BITS`: GPIO register
- `rd_data` out `DATA_W`: {`GPIOf0`, `LED_out`, `counter_set`} readback
- `led_clk` out 1: serial clock to the chain
- `led_sout` out 1: serial data, MSB first, inverted LED value (LEDs active-low)
- `led_clrn` out 1: chain clear, active-low
- `LED_PEN` out 1: chain latch/output-enable pulse
- `busy` out 1: frame in progress

## Operation
- Reset values: `counter_set`=0, `LED_out`=`LED_RST`, `GPIOf0`=0, `led_clk`=0, `led_sout`=0, `led_clrn`=1, `LED_PEN`=0, `busy`=0, pending=0, FSM in IDLE.
- Write: when `EN`=1, all three registers load from `P_Data` in that cycle. Registers hold when `EN`=0. Writes are accepted in every FSM state.
- Refresh request (req) = `Start` OR (`AUTO` AND `EN` AND the new LED field ≠ the current `LED_out`).
- FSM states, held in the shared enum:
  - IDLE: on req or pending, snapshot `~LED_out` into the shift register, clear pending, go to CLR.
  - CLR: `led_clrn`=0 for 2·DIV cycles, then SHIFT.
  - SHIFT: `LED_BITS` bit periods, each 2·DIV cycles long. `led_sout` takes the next bit (MSB first) at the start of the period while `led_clk`=0. `led_clk` goes 1 for the second DIV cycles. After the last bit, go to LATCH.
  - LATCH: `LED_PEN`=1, `led_clk`=0 for 2·DIV cycles, then IDLE.
- Snapshot semantics: the frame in flight transmits the value captured at IDLE exit.
- Boundary conditions:
  - A req while not IDLE sets pending. Multiple reqs collapse into one.
  - On LATCH→IDLE with pending=1, the next frame starts with the latest `LED_out`.
  - A req that arrives together with a write in IDLE snapshots the post-write value: the snapshot uses the `P_Data` LED field when `EN`=1.
  - `rst` asserted in any state aborts the frame and restores all reset values on the next edge.

## Timing
- Req in IDLE at cycle 0 → `busy`=1 and `led_clrn`=0 from cycle 1.
- Frame length is exactly 2·DIV·(`LED_BITS`+2) cycles; default is 72. `busy` drops on the first cycle back in IDLE.
- The external chain samples `led_sout` on the rising edge of `led_clk`. `led_sout` is stable DIV cycles before and DIV cycles after each rising edge.
- Register write to output: 1 cycle, with `LED_out` and `rd_data` valid after the `EN` edge.
- Back-to-back frames with pending set: one IDLE cycle between LATCH and the next CLR.

## Structure
- Package `spio_pkg`:
  - state enum {IDLE, CLR, SHIFT, LATCH};
  - field-offset localparams derived from the widths;
  - default `LED_RST`.
- Sub-module `spio_p2s`: the divider, bit counter, shift register and FSM, parametrised by `LED_BITS` and `DIV`, with start/busy handshake.
- The top level `spio_ser` holds the registers, readback, pending flag and AUTO compare.

## Test plan
- Reset: after `rst` for 2 cycles → `LED_out`=16'h5A5A, `counter_set`=0, `GPIOf0`=0, `led_clrn`=1, `busy`=0, `rd_data`=32'h0001_6968.
- Write 32'h1234ABCD with `EN` → `counter_set`=2'b01, `LED_out`=16'h2AF3, `GPIOf0`=14'h048D one cycle later. With AUTO, `busy` rises the following cycle.
- `Start` with LED=16'h5A5A, DIV=2 → `led_clrn` low for 4 cycles. The 16 bits sampled on rising `led_clk` are 1010_0101_1010_0101. `LED_PEN` is high for 4 cycles. `busy` lasts 72 cycles.
- Write LED=16'hFFFF at cycle 20 of a frame → the current frame still shifts its snapshot. A second frame follows after 1 IDLE cycle and shifts all 0s.
- AUTO=1, write the same LED value with a different `counter_set` → no frame starts and `busy` stays 0.
- `rst` in mid-SHIFT → next cycle all outputs at reset values, FSM IDLE, pending cleared.
